// File: rtl/alu_issue_rf.sv
// alu_issue_rf
//
// Operand-fetch and issue stage that sits in front of a combinational
// 32-bit ALU. The block holds a register file of 2^REG_AW words and
// accepts one request at a time. It drives registered operands and the
// opcode to the ALU, then captures the ALU result and zero flag. The
// result is written back to the destination register and reported on a
// one-cycle response strobe.
//
// Optional feature macro: ALU_IMM_EN
//   When defined, the ReqImm/ReqImmSel ports exist. With ReqImmSel=1 the
//   B operand is the sign-extended 16-bit immediate, and ReqRt is ignored.
//   When undefined, B always comes from RF[ReqRt].
//
// Ports
//   Clk, Rst                   clock, asynchronous active-high reset
//   ReqValid/ReqReady          request handshake
//   ReqOp, ReqRs, ReqRt, ReqRd request opcode and register addresses
//   ReqImm, ReqImmSel          immediate operand (ALU_IMM_EN only)
//   AluA, AluB, AluOp          registered drive to the ALU
//   AluOut, AluZero            ALU result and zero flag
//   RspValid, RspResult,       one-cycle result strobe with the captured
//   RspZero                    result and zero flag
//   LdEn, LdAddr, LdData       register preload port (writes in any state)
//   DbgAddr, DbgData           combinational register read

module alu_issue_rf #(
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Rst,

    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [3:0]        ReqOp,
    input  logic [REG_AW-1:0] ReqRs,
    input  logic [REG_AW-1:0] ReqRt,
    input  logic [REG_AW-1:0] ReqRd,
`ifdef ALU_IMM_EN
    input  logic [15:0]       ReqImm,
    input  logic              ReqImmSel,
`endif

    output logic [31:0]       AluA,
    output logic [31:0]       AluB,
    output logic [3:0]        AluOp,
    input  logic [31:0]       AluOut,
    input  logic              AluZero,

    output logic              RspValid,
    output logic [31:0]       RspResult,
    output logic              RspZero,

    input  logic              LdEn,
    input  logic [REG_AW-1:0] LdAddr,
    input  logic [31:0]       LdData,

    input  logic [REG_AW-1:0] DbgAddr,
    output logic [31:0]       DbgData
);

    localparam int DEPTH = 1 << REG_AW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [31:0]       a_q, b_q;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic [31:0]       result_q;
    logic              zero_q;

    logic              accept;
    logic              wb_we;
    logic [31:0]       b_src;

    // Read view of the register file; entry 0 is a constant zero.
    logic [31:0]       rf_word [DEPTH];

    assign accept = (state_q == ST_IDLE) && ReqValid;
    assign wb_we  = (state_q == ST_WB);

    // ------------------------------------------------------------------
    // Register file: one flop word per entry. R0 has no storage, so both
    // preload and writeback to it are discarded by construction. When a
    // writeback and a preload hit the same entry, the writeback wins.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rf
        if (gi == 0) begin : g_zero
            assign rf_word[gi] = '0;
        end else begin : g_word
            logic [31:0] entry_q;

            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    entry_q <= '0;
                end else if (wb_we && (rd_q == REG_AW'(gi))) begin
                    entry_q <= result_q;
                end else if (LdEn && (LdAddr == REG_AW'(gi))) begin
                    entry_q <= LdData;
                end
            end

            assign rf_word[gi] = entry_q;
        end
    end

    // B operand source: the register file, or the sign-extended immediate.
`ifdef ALU_IMM_EN
    assign b_src = ReqImmSel ? {{16{ReqImm[15]}}, ReqImm} : rf_word[ReqRt];
`else
    assign b_src = rf_word[ReqRt];
`endif

    // ------------------------------------------------------------------
    // Control FSM: IDLE -> EXEC -> WB -> IDLE
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ReqValid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand and result registers. The operands hold until the next
    // accept, and the result holds until the next EXEC capture. Operand
    // reads see the register file as it was before this edge's writes.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= rf_word[ReqRs];
                b_q  <= b_src;
                op_q <= ReqOp;
                rd_q <= ReqRd;
            end
            if (state_q == ST_EXEC) begin
                result_q <= AluOut;
                zero_q   <= AluZero;
            end
        end
    end

    assign ReqReady  = (state_q == ST_IDLE);
    assign RspValid  = (state_q == ST_WB);
    assign RspResult = result_q;
    assign RspZero   = zero_q;
    assign AluA      = a_q;
    assign AluB      = b_q;
    assign AluOp     = op_q;
    assign DbgData   = rf_word[DbgAddr];

endmodule

// File: tb/tb_alu_issue_rf.sv
// Bench for alu_issue_rf. A small behavioural ALU closes the loop:
// op 0 = AND, 1 = OR, 2 = A+B, 3 = A-B.
module tb_alu_issue_rf;

    logic        Clk;
    logic        Rst;
    logic        ReqValid;
    logic        ReqReady;
    logic [3:0]  ReqOp;
    logic [4:0]  ReqRs, ReqRt, ReqRd;
`ifdef ALU_IMM_EN
    logic [15:0] ReqImm;
    logic        ReqImmSel;
`endif
    logic [31:0] AluA, AluB;
    logic [3:0]  AluOp;
    logic [31:0] AluOut;
    logic        AluZero;
    logic        RspValid;
    logic [31:0] RspResult;
    logic        RspZero;
    logic        LdEn;
    logic [4:0]  LdAddr;
    logic [31:0] LdData;
    logic [4:0]  DbgAddr;
    logic [31:0] DbgData;

    int total = 0;
    int bad   = 0;

    alu_issue_rf #(.REG_AW(5)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqOp     (ReqOp),
        .ReqRs     (ReqRs),
        .ReqRt     (ReqRt),
        .ReqRd     (ReqRd),
`ifdef ALU_IMM_EN
        .ReqImm    (ReqImm),
        .ReqImmSel (ReqImmSel),
`endif
        .AluA      (AluA),
        .AluB      (AluB),
        .AluOp     (AluOp),
        .AluOut    (AluOut),
        .AluZero   (AluZero),
        .RspValid  (RspValid),
        .RspResult (RspResult),
        .RspZero   (RspZero),
        .LdEn      (LdEn),
        .LdAddr    (LdAddr),
        .LdData    (LdData),
        .DbgAddr   (DbgAddr),
        .DbgData   (DbgData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Bench ALU
    always_comb begin
        AluOut = '0;
        case (AluOp)
            4'd0: AluOut = AluA & AluB;
            4'd1: AluOut = AluA | AluB;
            4'd2: AluOut = AluA + AluB;
            4'd3: AluOut = AluA - AluB;
            default: AluOut = '0;
        endcase
    end
    assign AluZero = (AluOut == 32'd0);

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] va, vb;
        logic [3:0]  op;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_dbg(input string name, input logic [4:0] addr, input logic [31:0] exp);
        DbgAddr = addr;
        #1;
        chk(name, DbgData, exp);
    endtask

    // Preload one register; entered and left at posedge+1.
    task automatic load(input logic [4:0] addr, input logic [31:0] data);
        LdEn   = 1'b1;
        LdAddr = addr;
        LdData = data;
        @(posedge Clk); #1;
        LdEn   = 1'b0;
    endtask

    // Full request with checks at every stage; entered and left at posedge+1 in IDLE.
    task automatic do_req(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [3:0] op,
                          input logic [31:0] exp_a, input logic [31:0] exp_b,
                          input logic [31:0] exp_res, input logic exp_zero);
        ReqValid = 1'b1;
        ReqRs = rs; ReqRt = rt; ReqRd = rd; ReqOp = op;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        chk({tag, " exec ready"}, 32'(ReqReady), 32'd0);
        chk({tag, " exec rspvalid"}, 32'(RspValid), 32'd0);
        chk({tag, " AluA"}, AluA, exp_a);
        chk({tag, " AluB"}, AluB, exp_b);
        chk({tag, " AluOp"}, 32'(AluOp), 32'(op));
        @(posedge Clk); #1;
        chk({tag, " wb rspvalid"}, 32'(RspValid), 32'd1);
        chk({tag, " result"}, RspResult, exp_res);
        chk({tag, " zero"}, 32'(RspZero), 32'(exp_zero));
        @(posedge Clk); #1;
        chk({tag, " idle rspvalid"}, 32'(RspValid), 32'd0);
        chk({tag, " idle ready"}, 32'(ReqReady), 32'd1);
        chk_dbg({tag, " rd readback"}, rd, (rd == 5'd0) ? 32'd0 : exp_res);
        $display("txn %s: rs=%0d rt=%0d rd=%0d op=%0d A=%h B=%h res=%h zero=%0d",
                 tag, rs, rt, rd, op, AluA, AluB, RspResult, RspZero);
    endtask

    initial begin
        Rst = 1'b1; ReqValid = 1'b0; ReqOp = '0; ReqRs = '0; ReqRt = '0; ReqRd = '0;
        LdEn = 1'b0; LdAddr = '0; LdData = '0; DbgAddr = '0;
`ifdef ALU_IMM_EN
        ReqImm = '0; ReqImmSel = 1'b0;
`endif
        vecs[0] = '{rs:5'd1,  rt:5'd2,  rd:5'd3,  va:32'd1,          vb:32'd2,          op:4'd2, exp_res:32'd3,          exp_zero:1'b0};
        vecs[1] = '{rs:5'd4,  rt:5'd5,  rd:5'd0,  va:32'h0000000F,   vb:32'h0000000F,   op:4'd3, exp_res:32'd0,          exp_zero:1'b1};
        vecs[2] = '{rs:5'd6,  rt:5'd7,  rd:5'd8,  va:32'hFFFFFFFF,   vb:32'd1,          op:4'd2, exp_res:32'd0,          exp_zero:1'b1};
        vecs[3] = '{rs:5'd9,  rt:5'd10, rd:5'd11, va:32'hF0F0F0F0,   vb:32'h0FF00FF0,   op:4'd0, exp_res:32'h00F000F0,   exp_zero:1'b0};
        vecs[4] = '{rs:5'd9,  rt:5'd10, rd:5'd12, va:32'hF0F0F0F0,   vb:32'h0FF00FF0,   op:4'd1, exp_res:32'hFFF0FFF0,   exp_zero:1'b0};

        // Reset values
        #8;
        chk("reset ready", 32'(ReqReady), 32'd1);
        chk("reset rspvalid", 32'(RspValid), 32'd0);
        chk("reset AluA", AluA, 32'd0);
        chk("reset RspResult", RspResult, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk); #1;

        // Table-driven requests
        for (int i = 0; i < 5; i++) begin
            load(vecs[i].rs, vecs[i].va);
            load(vecs[i].rt, vecs[i].vb);
            do_req($sformatf("vec%0d", i), vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].op,
                   vecs[i].va, vecs[i].vb, vecs[i].exp_res, vecs[i].exp_zero);
        end
        chk_dbg("R0 after wb", 5'd0, 32'd0);

        // Held request then dependent request
        ReqValid = 1'b1; ReqRs = 5'd1; ReqRt = 5'd2; ReqRd = 5'd14; ReqOp = 4'd2;
        @(posedge Clk); #1;
        chk("dep exec AluA", AluA, 32'd1);
        chk("dep exec ready", 32'(ReqReady), 32'd0);
        @(posedge Clk); #1;
        chk("dep wb rspvalid", 32'(RspValid), 32'd1);
        chk("dep wb AluA held", AluA, 32'd1);
        ReqRs = 5'd14; ReqRt = 5'd1; ReqRd = 5'd15;
        @(posedge Clk); #1;
        chk("dep idle ready", 32'(ReqReady), 32'd1);
        chk("dep idle rspvalid", 32'(RspValid), 32'd0);
        chk("dep not accepted in wb", AluA, 32'd1);
        chk_dbg("dep R14", 5'd14, 32'd3);
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        chk("dep2 AluA", AluA, 32'd3);
        chk("dep2 AluB", AluB, 32'd1);
        chk("dep2 rspvalid", 32'(RspValid), 32'd0);
        @(posedge Clk); #1;
        chk("dep2 wb rspvalid", 32'(RspValid), 32'd1);
        chk("dep2 result", RspResult, 32'd4);
        @(posedge Clk); #1;
        chk("dep2 idle rspvalid", 32'(RspValid), 32'd0);
        chk_dbg("dep2 R15", 5'd15, 32'd4);
        $display("txn dependent: R14=3 then R15=R14+R1 result=%h", RspResult);

        // Load/writeback collision on R3
        load(5'd16, 32'd4);
        ReqValid = 1'b1; ReqRs = 5'd1; ReqRt = 5'd16; ReqRd = 5'd3; ReqOp = 4'd2;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        @(posedge Clk); #1;
        chk("coll result", RspResult, 32'd5);
        LdEn = 1'b1; LdAddr = 5'd3; LdData = 32'hDEADBEEF;
        @(posedge Clk); #1;
        LdEn = 1'b0;
        chk_dbg("coll R3 wb wins", 5'd3, 32'd5);
        $display("txn collision: ld R3=deadbeef vs wb R3=5 -> %h", DbgData);

        // Same-edge load to a source register is not seen by that request
        load(5'd17, 32'd7);
        LdEn = 1'b1; LdAddr = 5'd17; LdData = 32'd99;
        ReqValid = 1'b1; ReqRs = 5'd17; ReqRt = 5'd0; ReqRd = 5'd18; ReqOp = 4'd2;
        @(posedge Clk); #1;
        LdEn = 1'b0; ReqValid = 1'b0;
        chk("same-edge AluA old", AluA, 32'd7);
        chk_dbg("same-edge R17 new", 5'd17, 32'd99);
        @(posedge Clk); #1;
        chk("same-edge result", RspResult, 32'd7);
        @(posedge Clk); #1;
        chk_dbg("same-edge R18", 5'd18, 32'd7);
        $display("txn same-edge load: A=%h R18=%h", AluA, DbgData);

        // Preload to R0 is discarded
        load(5'd0, 32'd1234);
        chk_dbg("R0 load discarded", 5'd0, 32'd0);
        $display("txn load R0: reads %h", DbgData);

`ifdef ALU_IMM_EN
        ReqImmSel = 1'b1; ReqImm = 16'hFFFF;
        do_req("imm", 5'd1, 5'd2, 5'd19, 4'd2, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1);
        ReqImmSel = 1'b0; ReqImm = '0;
`endif

        // Nonzero state ahead of a mid-EXEC reset
        do_req("pre-reset", 5'd2, 5'd2, 5'd22, 4'd2, 32'd2, 32'd2, 32'd4, 1'b0);
        load(5'd20, 32'd55);
        ReqValid = 1'b1; ReqRs = 5'd20; ReqRt = 5'd2; ReqRd = 5'd21; ReqOp = 4'd2;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        chk("mid-exec AluA", AluA, 32'd55);
        #1 Rst = 1'b1;
        #1;
        chk("rst ready", 32'(ReqReady), 32'd1);
        chk("rst rspvalid", 32'(RspValid), 32'd0);
        chk("rst AluA", AluA, 32'd0);
        chk("rst AluB", AluB, 32'd0);
        chk("rst AluOp", 32'(AluOp), 32'd0);
        chk("rst RspResult", RspResult, 32'd0);
        chk_dbg("rst R20", 5'd20, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk); #1;
        chk("post-rst ready", 32'(ReqReady), 32'd1);
        chk("post-rst rspvalid", 32'(RspValid), 32'd0);
        chk_dbg("post-rst R21 no wb", 5'd21, 32'd0);
        $display("txn reset mid-exec: ready=%0d rspvalid=%0d", ReqReady, RspValid);
        do_req("post-reset", 5'd1, 5'd2, 5'd1, 4'd2, 32'd0, 32'd0, 32'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_rf.md
# alu_issue_rf

Operand-fetch and issue stage directly upstream of the 32-bit `alu`. It holds a 32 x 32-bit register file, accepts one ALU request at a time over a valid/ready handshake, and presents registered operands and opcode to the ALU. It then captures the ALU's `Out`/`Zero` pair, writes the result back to the destination register, and reports it on a one-cycle response strobe.

## Interface
- `REG_AW`, default 5: register address width; the file depth is 2^REG_AW.
- `Clk` in 1: sole clock; all state updates on the rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `ReqValid` in 1: request present.
- `ReqReady` out 1: stage can accept a request.
- `ReqOp` in 4: ALU opcode, passed through unchanged.
- `ReqRs` in REG_AW: source register for ALU A.
- `ReqRt` in REG_AW: source register for ALU B.
- `ReqRd` in REG_AW: destination register.
- `ReqImm` in 16: immediate value (only with `ALU_IMM_EN`).
- `ReqImmSel` in 1: 1 selects the immediate for B (only with `ALU_IMM_EN`).
- `AluA` out 32, `AluB` out 32, `AluOp` out 4: registered drive to `alu` A/B/Op.
- `AluOut` in 32, `AluZero` in 1: from `alu` Out/Zero.
- `RspValid` out 1: result strobe, one cycle wide.
- `RspResult` out 32, `RspZero` out 1: captured ALU result and zero flag.
- `LdEn` in 1, `LdAddr` in REG_AW, `LdData` in 32: external register preload port.
- `DbgAddr` in REG_AW, `DbgData` out 32: combinational register read for benches.

## Operation
- States: IDLE, EXEC, WB. Encoding is free; exactly these three states.
- **IDLE**
  - `ReqReady`=1.
  - On `ReqValid`: latch `ReqOp`→opcode reg and `ReqRd`→rd reg, read `RF[ReqRs]`→A reg and `RF[ReqRt]`→B reg, then go to EXEC.
  - Without `ReqValid`: stay in IDLE.
- **EXEC**
  - `ReqReady`=0.
  - `AluA`/`AluB`/`AluOp` are stable from the operand regs; the ALU is combinational.
  - At the clock edge: `AluOut`→`RspResult`, `AluZero`→`RspZero`, then go to WB.
- **WB**
  - `ReqReady`=0, `RspValid`=1.
  - At the clock edge: `RF[rd]`←`RspResult` unless rd==0, then go to IDLE.
- R0 is hardwired to zero: reads return 0 and writes to it are discarded (both load and writeback).
- `AluA`/`AluB`/`AluOp` hold their value until the next accept. `RspResult`/`RspZero` hold until the next EXEC capture.
- Preload: `LdEn` writes `RF[LdAddr]`←`LdData` at the edge, in any state.
  - If the WB writeback and `LdEn` target the same address in the same cycle, the writeback wins.
- A read at accept sees the array before that edge's writes. A same-edge `LdEn` to a source register is therefore not visible to that request.
- A request presented outside IDLE is not accepted. The requester holds `ReqValid` and its fields until `ReqReady`=1.
- Arithmetic is done entirely in the `alu`. This block applies no width change except the immediate extension.

## Timing
- Request accepted at edge N → ALU inputs valid after N → result captured at N+1 → `RspValid` high during the cycle after N+1 → writeback at N+2.
- Latency is 2 cycles from accept to `RspValid`. Throughput is one request per 3 cycles.
- A back-to-back dependent request accepted at N+3 reads the written-back value (no hazard).
- Reset, asynchronous and at any point (including mid-EXEC or mid-WB):
  - state→IDLE, all RF entries→0;
  - `AluA`/`AluB`/`AluOp`/`RspResult`/`RspZero`/`RspValid`→0;
  - `ReqReady`=1 while IDLE;
  - any in-flight request is dropped with no writeback.
- After `Rst` deasserts, the first accept is possible at the first rising edge.

## Configuration
- Macro `ALU_IMM_EN`.
- Defined: the `ReqImm`/`ReqImmSel` ports exist. At accept with `ReqImmSel`=1, the B reg←{{16{ReqImm[15]}},ReqImm}, i.e. sign-extended; `ReqRt` is ignored.
- Undefined: the ports are absent and B always comes from `RF[ReqRt]`.

## Test plan
- **Reset values:** assert `Rst` mid-EXEC → next cycle state IDLE, `ReqReady`=1, `RspValid`=0, `AluA`=0, `DbgData`(any addr)=0.
- **Basic request:** preload R1=32'd1, R2=32'd2; request Op=4'd2 (bench ALU: A+B), Rs=1, Rt=2, Rd=3 → `AluA`=1, `AluB`=2 in EXEC. `RspValid` pulses one cycle, 2 cycles after accept, with `RspResult`=32'd3, `RspZero`=0, and DbgData(R3)=3 afterwards.
- **Zero flag and R0 write:** R4=R5=32'h0000000F; Op=4'd3 (A−B), Rd=0 → `RspResult`=0, `RspZero`=1, R0 still reads 0.
- **Dependent request and holding:** a request accepted immediately after WB, using Rs=3 from the previous result → operand A=3. `ReqValid` held high during EXEC/WB → not accepted until IDLE, and exactly one response per request.
- **Load/writeback collision:** `LdEn` to R3 with 32'hDEADBEEF in the WB cycle of a request writing R3=5 → R3 reads 5.
- **Immediate path:** with `ALU_IMM_EN`, ReqImmSel=1, ReqImm=16'hFFFF, Rs=1 (value 1), Op=A+B → `AluB`=32'hFFFFFFFF, `RspResult`=0, `RspZero`=1.
